// File: rtl/pipe_share_rr_arbiter_pkg.sv
// Shared helpers for the pipe-sharing round-robin arbiter.
package pipe_share_rr_arbiter_pkg;

  // Requester-id / pointer width. It is kept at least one bit wide so that a degenerate count still yields a legal vector.
  function automatic int id_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/pipe_share_rr_arbiter_if.sv
// Requester, shared-pipe and response signals of the pipe-sharing arbiter.
interface pipe_share_rr_arbiter_if #(
  parameter int n_req = 4,
  parameter int width = 32
);
  logic [n_req-1:0]            req_vld;
  logic [n_req-1:0][width-1:0] req_data;
  logic [n_req-1:0]            req_rdy;
  logic                        pipe_in_vld;
  logic [width-1:0]            pipe_in_data;
  logic                        pipe_out_vld;
  logic [width-1:0]            pipe_out_data;
  logic [n_req-1:0]            rsp_vld;
  logic [width-1:0]            rsp_data;
  logic                        err;

  modport master (
    output req_vld, req_data, pipe_out_vld, pipe_out_data,
    input  req_rdy, pipe_in_vld, pipe_in_data, rsp_vld, rsp_data, err
  );

  modport slave (
    input  req_vld, req_data, pipe_out_vld, pipe_out_data,
    output req_rdy, pipe_in_vld, pipe_in_data, rsp_vld, rsp_data, err
  );
endinterface

// File: rtl/pipe_share_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter
  import pipe_share_rr_arbiter_pkg::*;
#(
  parameter int n_req = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req,
  output logic [n_req-1:0]       grant,
  output logic                   grant_vld,
  output logic [id_w(n_req)-1:0] grant_id
);
  localparam int id_w_c = id_w(n_req);
  localparam logic [id_w_c-1:0] last_id_c = id_w_c'(n_req - 1);

  logic [id_w_c-1:0] ptr_r;
  logic [id_w_c-1:0] ptr_nxt_s;
  logic [id_w_c-1:0] idx_s;

  // Search upward from ptr, wrapping at n_req; the first asserted request wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx_s     = '0;
    for (int k = 0; k < n_req; k++) begin
      idx_s = id_w_c'((int'(ptr_r) + k) % n_req);
      if (!grant_vld && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_vld    = 1'b1;
        grant_id     = idx_s;
      end else begin
        grant[idx_s] = 1'b0;
      end
    end
  end

  // Pointer successor wraps explicitly so non-power-of-2 counts stay in range.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (grant_id == last_id_c) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_id + id_w_c'(1);
    end
  end

  // Pointer register; it holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (grant_vld) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/pipe_share_rr_arbiter.sv
// Shares one fixed-latency pipe among n_req requesters and steers results back by id tag.
// Optional check logic: define PIPE_SHARE_RR_ARBITER_CHECK_EN.
module pipe_share_rr_arbiter
  import pipe_share_rr_arbiter_pkg::*;
#(
  parameter int n_req   = 4,
  parameter int width   = 32,
  parameter int latency = 8
) (
  input logic                   clk,
  input logic                   rst,
  pipe_share_rr_arbiter_if.slave bus
);
  localparam int id_w_c = id_w(n_req);

  // The tag stage is declared here because its id field depends on this instance's n_req.
  typedef struct packed {
    logic              vld;
    logic [id_w_c-1:0] id;
  } tag_t;

  logic [n_req-1:0]  grant_s;
  logic              grant_vld_s;
  logic [id_w_c-1:0] grant_id_s;
  tag_t              tag_r [latency];
  tag_t              tag_out_s;

  rr_arbiter #(
    .n_req (n_req)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_vld),
    .grant     (grant_s),
    .grant_vld (grant_vld_s),
    .grant_id  (grant_id_s)
  );

  assign bus.req_rdy     = grant_s;
  assign bus.pipe_in_vld = grant_vld_s;
  assign bus.rsp_data    = bus.pipe_out_data;
  assign tag_out_s       = tag_r[latency-1];

  // Operand mux into the pipe and response steering out of it.
  always_comb begin
    bus.pipe_in_data = '0;
    bus.rsp_vld      = '0;
    if (grant_vld_s) begin
      bus.pipe_in_data = bus.req_data[grant_id_s];
    end else begin
      bus.pipe_in_data = '0;
    end
    if (bus.pipe_out_vld && tag_out_s.vld) begin
      bus.rsp_vld[tag_out_s.id] = 1'b1;
    end else begin
      bus.rsp_vld = '0;
    end
  end

  // Tag chain mirrors the pipe: its last stage lines up with pipe_out_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < latency; s++) begin
        tag_r[s] <= '0;
      end
    end else begin
      tag_r[0].vld <= grant_vld_s;
      tag_r[0].id  <= grant_id_s;
      for (int s = 1; s < latency; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

`ifdef PIPE_SHARE_RR_ARBITER_CHECK_EN
  logic err_r;

  // Sticky mismatch flag between the pipe's valid and the tag chain.
  always_ff @(posedge clk) begin
    assert (rst || (bus.pipe_out_vld == tag_out_s.vld))
      else $error("pipe_share_rr_arbiter: pipe_out_vld=%0b but tag vld=%0b", bus.pipe_out_vld, tag_out_s.vld);
    if (rst) begin
      err_r <= 1'b0;
    end else if (bus.pipe_out_vld != tag_out_s.vld) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_share_rr_arbiter.sv
// Scoreboard bench: a reference round-robin model predicts grants and queues the expected responses.
module tb_pipe_share_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 8;

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_vld = 1'b0;
  logic exp_err = 1'b0;

  logic [LAT-1:0] pv_r;
  logic [W-1:0]   pd_r [LAT];
  logic [W-1:0]   data_m [N];
  exp_t           sb_q [$];
  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc = 0;
  int             m_ptr = 0;

  always #5 clk = ~clk;

  pipe_share_rr_arbiter_if #(.n_req(N), .width(W)) bus ();

  pipe_share_rr_arbiter #(
    .n_req   (N),
    .width   (W),
    .latency (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared-pipe model: an identity delay of LAT cycles, reset together with the DUT.
  always @(posedge clk) begin
    if (rst) begin
      pv_r <= '0;
    end else begin
      pv_r <= {pv_r[LAT-2:0], bus.pipe_in_vld};
    end
    pd_r[0] <= bus.pipe_in_data;
    for (int s = 1; s < LAT; s++) begin
      pd_r[s] <= pd_r[s-1];
    end
  end

  assign bus.pipe_out_vld  = pv_r[LAT-1] | force_vld;
  assign bus.pipe_out_data = pd_r[LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive requests, predict and compare at the falling edge, advance.
  task automatic run_cycle(input logic [N-1:0] vld);
    logic [N-1:0] g;
    logic [N-1:0] rv;
    logic [W-1:0] exp_d;
    int           gid;
    int           idx;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      bus.req_data[i] = data_m[i];
    end
    bus.req_vld = vld;
    @(negedge clk);
    g     = '0;
    gid   = -1;
    exp_d = '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (gid < 0 && vld[idx]) begin
        gid    = idx;
        g[idx] = 1'b1;
        exp_d  = data_m[idx];
      end
    end
    check_eq("req_rdy", 64'(bus.req_rdy), 64'(g));
    check_eq("pipe_in_vld", 64'(bus.pipe_in_vld), 64'(|vld));
    check_eq("pipe_in_data", 64'(bus.pipe_in_data), 64'(exp_d));
    rv = '0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      rv[e.id] = 1'b1;
      check_eq("rsp_data", 64'(bus.rsp_data), 64'(e.data));
    end
    check_eq("rsp_vld", 64'(bus.rsp_vld), 64'(rv));
    check_eq("err", 64'(bus.err), 64'(exp_err));
    if (gid >= 0) begin
      e.due  = cyc + LAT;
      e.id   = gid;
      e.data = data_m[gid];
      sb_q.push_back(e);
      m_ptr = (gid + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (gid >= 0) begin
      data_m[gid] = $urandom();
    end
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    bus.req_vld = '0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc += n;
    sb_q.delete();
    m_ptr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      data_m[i] = 32'h1000_0000 + 32'(i);
    end
    bus.req_vld  = '0;
    bus.req_data = '0;
    reset_cycles(3);
    run_cycle(4'b0000);

    // Single request: grant same cycle, response LAT cycles later.
    data_m[1] = 32'h0000_0025;
    run_cycle(4'b0010);
    repeat (LAT + 2) run_cycle(4'b0000);

    // All requesters held valid: strict rotation.
    repeat (12) run_cycle(4'b1111);
    repeat (LAT + 2) run_cycle(4'b0000);

    // Wrap and skip: move ptr to 3, then 1001 and a later 0110.
    run_cycle(4'b0100);
    repeat (3) run_cycle(4'b1001);
    repeat (2) run_cycle(4'b0110);
    repeat (LAT + 2) run_cycle(4'b0000);

    // Idle gaps between requests.
    run_cycle(4'b0001);
    run_cycle(4'b0000);
    run_cycle(4'b0000);
    run_cycle(4'b0100);
    run_cycle(4'b1000);
    repeat (LAT + 2) run_cycle(4'b0000);

    // Reset with tags in flight: ptr ends at 1, responses must be dropped.
    repeat (5) run_cycle(4'b1111);
    reset_cycles(1);
    repeat (LAT + 4) run_cycle(4'b0000);
    run_cycle(4'b1111);
    repeat (LAT + 2) run_cycle(4'b0000);

    // Pipe valid with no tag behind it.
    force_vld = 1'b1;
    run_cycle(4'b0000);
    force_vld = 1'b0;
`ifdef PIPE_SHARE_RR_ARBITER_CHECK_EN
    exp_err = 1'b1;
`endif
    repeat (3) run_cycle(4'b0000);
    reset_cycles(2);
    exp_err = 1'b0;
    run_cycle(4'b0000);

    // Random request patterns, including simultaneous grant and response.
    repeat (40) run_cycle(4'($urandom_range(0, 15)));
    repeat (LAT + 2) run_cycle(4'b0000);
    check_eq("drain", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
